// File: rtl/coo_stream_feeder.sv
`default_nettype none
// ============================================================================
// Module      : coo_stream_feeder
// Description : Walks per-channel COO entry memories and emits one beat per
//               issue cycle, padding exhausted lanes with the row sentinel.
// Revision    : 1.0 - initial release
// ============================================================================
module coo_stream_feeder #(
  parameter int NUM_CHANNELS = 4,
  parameter int MATRIX_SIZE  = 128,
  parameter int ADDR_W       = 10,
  parameter int NNZ_W        = 11
) (
  input  logic                                  clk,
  input  logic                                  rst_l,
  input  logic                                  start,
  input  logic [NUM_CHANNELS-1:0][NNZ_W-1:0]    nnz_count,
  input  logic                                  hold,
  output logic                                  mem_rd_en,
  output logic [NUM_CHANNELS-1:0][ADDR_W-1:0]   mem_addr,
  input  logic [NUM_CHANNELS-1:0][31:0]         mem_value,
  input  logic [NUM_CHANNELS-1:0][31:0]         mem_col,
  input  logic [NUM_CHANNELS-1:0][31:0]         mem_row,
  output logic [NUM_CHANNELS-1:0][31:0]         values,
  output logic [NUM_CHANNELS-1:0][31:0]         col_id,
  output logic [NUM_CHANNELS-1:0][31:0]         row_id,
  output logic                                  rdy,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  err
);

  localparam logic [NNZ_W-1:0] NNZ_MAX  = NNZ_W'(1 << ADDR_W);
  localparam logic [31:0]      SENTINEL = 32'(MATRIX_SIZE);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e                               state_q, state_d;
  logic                                 flush_cnt_q, flush_cnt_d;
  logic [NUM_CHANNELS-1:0][NNZ_W-1:0]   nnz_q, nnz_d;
  logic [NUM_CHANNELS-1:0][NNZ_W-1:0]   ptr_q, ptr_d;
  logic                                 s1_valid_q, s1_valid_d;
  logic [NUM_CHANNELS-1:0]              s1_mask_q, s1_mask_d;
  logic [NUM_CHANNELS-1:0][31:0]        values_q, values_d;
  logic [NUM_CHANNELS-1:0][31:0]        col_q, col_d;
  logic [NUM_CHANNELS-1:0][31:0]        row_q, row_d;
  logic                                 rdy_q, rdy_d;
  logic                                 err_q, err_d;

  logic                                 issue;
  logic                                 accept;
  logic [NUM_CHANNELS-1:0]              active;

  always_comb begin
    issue  = (state_q == ST_FETCH) && !hold;
    accept = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      active[k]   = ptr_q[k] < nnz_q[k];
      mem_addr[k] = ptr_q[k][ADDR_W-1:0];
    end
    mem_rd_en = issue && (|active);
  end

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    nnz_d       = nnz_q;
    ptr_d       = ptr_q;
    err_d       = err_q;
    values_d    = values_q;
    col_d       = col_q;
    row_d       = row_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          state_d = ST_FETCH;
          ptr_d   = '0;
          err_d   = 1'b0;
          for (int k = 0; k < NUM_CHANNELS; k++) begin
            nnz_d[k] = (nnz_count[k] > NNZ_MAX) ? NNZ_MAX : nnz_count[k];
          end
        end
      end
      ST_FETCH: begin
        if (issue) begin
          for (int k = 0; k < NUM_CHANNELS; k++) begin
            if (active[k]) ptr_d[k] = ptr_q[k] + NNZ_W'(1);
          end
          // An issue with no active lane is the terminator beat
          if (!(|active)) begin
            state_d     = ST_FLUSH;
            flush_cnt_d = 1'b0;
          end
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q) state_d = ST_DONE;
        else             flush_cnt_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    s1_valid_d = issue;
    s1_mask_d  = active;
    rdy_d      = s1_valid_q;

    if (s1_valid_q) begin
      for (int k = 0; k < NUM_CHANNELS; k++) begin
        if (s1_mask_q[k]) begin
          values_d[k] = mem_value[k];
          col_d[k]    = mem_col[k];
          row_d[k]    = mem_row[k];
          if (mem_row[k] >= SENTINEL) err_d = 1'b1;
        end else begin
          values_d[k] = '0;
          col_d[k]    = '0;
          row_d[k]    = SENTINEL;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state_q     <= ST_IDLE;
      flush_cnt_q <= 1'b0;
      nnz_q       <= '0;
      ptr_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_mask_q   <= '0;
      values_q    <= '0;
      col_q       <= '0;
      row_q       <= '0;
      rdy_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      nnz_q       <= nnz_d;
      ptr_q       <= ptr_d;
      s1_valid_q  <= s1_valid_d;
      s1_mask_q   <= s1_mask_d;
      values_q    <= values_d;
      col_q       <= col_d;
      row_q       <= row_d;
      rdy_q       <= rdy_d;
      err_q       <= err_d;
    end
  end

  assign values = values_q;
  assign col_id = col_q;
  assign row_id = row_q;
  assign rdy    = rdy_q;
  assign err    = err_q;
  assign busy   = (state_q == ST_FETCH) || (state_q == ST_FLUSH);
  assign done   = (state_q == ST_DONE);

endmodule
`default_nettype wire
